// File: rtl/data_memory_responder_if.sv
// Request/response bundle between the MEM stage and the data memory responder.
// master: the MEM stage, which drives MEMread/MEMwrite/address/data.
// slave : the responder, which returns MEM_result and ready.
interface data_memory_responder_if;
  logic        MEMread;     // read request
  logic        MEMwrite;    // write request (wins when both are high)
  logic [31:0] address;     // byte address
  logic [31:0] data;        // write data
  logic [31:0] MEM_result;  // last completed read value
  logic        ready;       // 0 = access in progress, pipeline frozen

  modport master (
    output MEMread, MEMwrite, address, data,
    input  MEM_result, ready
  );

  modport slave (
    input  MEMread, MEMwrite, address, data,
    output MEM_result, ready
  );
endinterface

// File: rtl/data_memory_responder.sv
// Data memory responder: services MEM-stage reads/writes against a DEPTH-word array.
// Latency: ready low for WAIT_CYCLES+1 cycles from the cycle a request is seen, high for one DONE cycle.
// Backpressure: ready=0 freezes the pipeline; inputs are latched on acceptance and ignored afterwards.
// Ports: clk, rst (sync, active-high), bus (slave modport: MEMread, MEMwrite, address, data -> MEM_result, ready).
module data_memory_responder #(
  parameter int DEPTH       = 64,    // words stored, power of two, >= 2
  parameter int BASE_ADDR   = 1024,  // byte address of word 0
  parameter int WAIT_CYCLES = 4      // wait states per access, >= 1
) (
  input  logic                      clk,
  input  logic                      rst,
  data_memory_responder_if.slave    bus
);

  localparam int              AW       = $clog2(DEPTH);
  localparam int              CW       = $clog2(WAIT_CYCLES + 1);
  localparam logic [31:0]     BASE     = 32'(BASE_ADDR);
  // Byte span of the array; one bit wider than an address so it cannot wrap.
  localparam logic [32:0]     SPAN     = 33'(4 * DEPTH);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(WAIT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [CW-1:0] cnt;

  // Request captured when it is accepted in IDLE.
  logic        lat_wr;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_q;

  logic        req;
  logic        accept;
  logic        fire;
  logic        ready;
  logic [31:0] offset;
  logic        in_range;
  logic [AW-1:0] word_idx;

  assign req    = bus.MEMread | bus.MEMwrite;
  assign accept = (state == IDLE) && req;
  // The access itself happens on the edge that ends the last BUSY cycle.
  assign fire   = (state == BUSY) && (cnt == '0);

  // Address decode on the latched address. The subtraction wraps for
  // addresses below BASE, so the lower bound is checked separately.
  assign offset   = lat_addr - BASE;
  assign in_range = (lat_addr >= BASE) && ({1'b0, offset} < SPAN);
  assign word_idx = offset[AW+1:2];

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      // The pipeline advances on the DONE edge, so the request is not
      // looked at here; a held request is picked up in the next IDLE.
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    ready = 1'b0;
    case (state)
      IDLE:    ready = !req;
      DONE:    ready = 1'b1;
      default: ready = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request latch and wait-state counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      lat_wr   <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
    end else if (accept) begin
      // Both requests high is handled as a write.
      lat_wr   <= bus.MEMwrite;
      lat_addr <= bus.address;
      lat_data <= bus.data;
      cnt      <= CNT_LOAD;
    end else if ((state == BUSY) && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Storage array. Reset clears every word, which also drops a write that
  // is still counting down.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (fire && lat_wr && in_range) begin
      mem[word_idx] <= lat_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Read result register: only a completed read updates it, so it holds
  // across writes and idle periods.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q <= '0;
    end else if (fire && !lat_wr) begin
      rd_q <= in_range ? mem[word_idx] : 32'h0;
    end
  end

  assign bus.MEM_result = rd_q;
  assign bus.ready      = ready;

endmodule
